// File: rtl/updown_mod_counter.sv
// Loadable up/down counter with a programmable modulus (0..limit), wrap or
// saturate behaviour at the bounds, an optional clock-enable prescaler and a
// registered terminal-count pulse suitable for cascading into another en.
module updown_mod_counter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic             tick;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  generate
    if (DIV <= 1) begin : g_no_pre
      // Without a prescaler every enabled cycle is a count step.
      assign tick = en;
    end else begin : g_pre
      localparam int             PRE_W    = $clog2(DIV);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

      logic [PRE_W-1:0] pre;

      assign tick = en && (pre == PRE_LAST);

      // Prescaler: counts enabled cycles, restarts on a load or after its last phase.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre <= '0;
        end else if (!load_n) begin
          pre <= '0;
        end else if (en) begin
          pre <= tick ? '0 : pre + 1'b1;
        end
      end
    end
  endgenerate

  // Next count and terminal-count: load beats tick; bounds are compared
  // before any increment/decrement so nothing overflows WIDTH bits.
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (!load_n) begin
      q_nxt = (d > limit) ? limit : d;
    end else if (tick) begin
      if (q > limit) begin
        // limit was lowered under us; pull back into range quietly
        q_nxt = limit;
      end else if (up) begin
        if (q == limit) begin
          tc_nxt = 1'b1;
          q_nxt  = sat ? limit : '0;
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = sat ? '0 : limit;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  // Output registers: q and tc are both registered, so no input reaches an
  // output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

endmodule
